// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port unified RAM between the instruction-fetch port and
//   the data (load/store) port. Each access runs IDLE -> ISSUE -> (WAIT) -> RESP.
//   Data normally wins ties. Fetch is forced through after STARVE_LIMIT
//   consecutive data grants made while fetch was waiting.
//
// Ports
//   clk, rst                  clock and synchronous active-low reset
//   if_req/if_addr            fetch request and address, held until if_ack
//   if_rdata/if_ack           registered fetch data and one-cycle completion pulse
//   flush                     cancels delivery of an in-flight fetch
//   d_req/d_we/d_addr/d_wdata data request, held until d_ack
//   d_rdata/d_ack             registered load data and one-cycle completion pulse
//   ram_en/ram_we/ram_addr/ram_wdata  registered RAM command, active only in ISSUE
//   ram_rdata                 RAM read data, valid RAM_LATENCY cycles after issue
//   stall_req                 combinational stall toward the pipeline control
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_req
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic       r_grant_d;  // 1 = data port owns the current transaction
  logic       r_we;
  logic [2:0] r_cnt;
  logic [3:0] r_starve;
  logic       r_cancel;
  logic       w_fetch_wins;

  // Fetch takes priority only when data is absent or fetch has been starved.
  assign w_fetch_wins = if_req && (!d_req || (r_starve == LIM));

  // Stall while either port has an outstanding request not being acked this cycle.
  assign stall_req = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Transaction sequencer: arbitration, RAM command, response capture and acks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_grant_d <= 1'b0;
      r_we      <= 1'b0;
      r_cnt     <= 3'd0;
      r_starve  <= 4'd0;
      r_cancel  <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // Acks and the RAM strobe are single-cycle unless re-asserted below.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_fetch_wins) begin
            r_grant_d <= 1'b0;
            r_we      <= 1'b0;
            ram_en    <= 1'b1;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            r_starve  <= 4'd0;
            r_state   <= S_ISSUE;
          end else if (d_req) begin
            r_grant_d <= 1'b1;
            r_we      <= d_we;
            ram_en    <= 1'b1;
            ram_we    <= d_we;
            ram_addr  <= d_addr;
            ram_wdata <= d_wdata;
            // Count data grants that leave fetch waiting; saturate at the limit.
            if (if_req) begin
              if (r_starve != LIM) begin
                r_starve <= r_starve + 4'd1;
              end else begin
                r_starve <= r_starve;
              end
            end else begin
              r_starve <= 4'd0;
            end
            r_state <= S_ISSUE;
          end else begin
            r_starve <= 4'd0;
            r_state  <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!r_grant_d && flush) begin
            r_cancel <= 1'b1;
          end
          r_cnt <= LAT;
          // Writes complete without waiting for the RAM; only data can write.
          if (r_we) begin
            d_ack   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!r_grant_d && flush) begin
            r_cancel <= 1'b1;
          end
          if (r_cnt == 3'd1) begin
            r_state <= S_RESP;
            if (r_grant_d) begin
              d_rdata <= ram_rdata;
              d_ack   <= 1'b1;
            end else if (!(r_cancel || flush)) begin
              // A flush in this very cycle must also suppress delivery.
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end else begin
              if_rdata <= if_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (!r_grant_d && flush) begin
            r_cancel <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified RAM between the core's instruction-fetch port and its data (load/store) port.
- Sits between the pipeline (pc_reg/if_id fetch side, mem stage data side) and the RAM.
- Arbitrates the two ports, sequences each RAM access with a configurable read latency, returns data with an ack pulse, and raises a stall request toward ctrl while any port is waiting.

Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width.
- RAM_LATENCY, 1, cycles from the RAM issue edge to valid ram_rdata (1..7).
- STARVE_LIMIT, 4, consecutive data grants made while fetch is waiting before fetch is forced to win (1..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address, stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; registered; held until the next fetch ack.
- if_ack  out  1  one-cycle completion pulse for fetch.
- flush  in  1  pipeline flush; cancels delivery of an in-flight fetch.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data; registered; held until the next data read ack.
- d_ack  out  1  one-cycle completion pulse for data.
- ram_en  out  1  RAM access strobe, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM read data.
- stall_req  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational.

Behaviour:
- States:
  - IDLE: arbitrate.
  - ISSUE: ram_en=1 for exactly this one cycle.
  - WAIT: down-counter loaded with RAM_LATENCY.
  - RESP: ack cycle.
- Transitions:
  - IDLE -> ISSUE when any req is high.
  - ISSUE -> RESP for a write.
  - ISSUE -> WAIT for a read.
  - WAIT -> RESP when the counter reaches 1; ram_rdata is captured into the granted port's rdata register at that edge.
  - RESP -> IDLE always.
- Latency from request seen in IDLE at cycle 0:
  - Read: ram_en in cycle 1, ack in cycle 2+RAM_LATENCY (cycle 3 at default).
  - Write: ram_en/ram_we in cycle 1, ack in cycle 2.
  - Back-to-back minimum period: 4 cycles per read, 3 per write (default latency).
- RESP cycle: the acked requester's req is still high and is ignored. Arbitration occurs only in IDLE.
- Arbitration in IDLE:
  - If only one port requests, it is granted.
  - If both request, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) on each data grant made while if_req is high.
  - Clears on every fetch grant.
  - Clears when if_req is low in IDLE.
- Grant, address, we and wdata are latched in the IDLE->ISSUE edge. Port inputs are not sampled again until the next IDLE.
- ram_en, ram_we, ram_addr and ram_wdata are 0 outside ISSUE (ram_addr/wdata may hold, but ram_en=0).
- flush:
  - If high in any cycle while a fetch transaction is in ISSUE/WAIT/RESP, a sticky cancel bit is set.
  - On cancel, the transaction completes on the RAM, if_rdata is not updated, and if_ack is suppressed; the FSM still passes through RESP.
  - The cancel bit clears in IDLE.
  - flush never affects data transactions.
- Reset values (rst=0 at an edge): state IDLE, if_ack=d_ack=0, if_rdata=d_rdata=0, ram_en=ram_we=0, ram_addr=ram_wdata=0, starve_cnt=0, cancel=0.
  - Reset mid-transaction aborts it with no ack.
  - ram_en is low in the cycle after the reset edge.

Test Plan:
- Single fetch, if_addr=0x100, ram returns 0x24020005: ram_en in cycle 1, if_ack and if_rdata=0x24020005 in cycle 3, stall_req high cycles 0-2, low in cycle 3.
- Data write d_addr=0x2000, d_wdata=0xDEADBEEF: ram_en=ram_we=1 with ram_addr=0x2000 in cycle 1, d_ack in cycle 2, if_ack never pulses.
- if_req and d_req (read) high continuously with STARVE_LIMIT=4: grant order D,D,D,D,F,D,D,D,D,F; each ack carries the correct port's data.
- RAM_LATENCY=3 read: d_ack exactly at cycle 5; ram_en high only in cycle 1.
- flush pulse in WAIT of a fetch: no if_ack, if_rdata keeps its previous value, FSM back in IDLE at cycle 4, and a pending d_req is granted there.
- rst=0 during WAIT: next cycle all outputs 0 and state IDLE; a request held through reset release is served normally with ack 3 cycles after release.
